// File: rtl/zstr_pkg.sv
// Shared z-stream types and helpers: FSM state encoding and the
// rotating-priority search used by the arbiters and muxes.
package zstr_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } zstr_state_t;

  // Largest port count the search helper supports.
  localparam int unsigned ZSTR_MAX_N = 32;
  localparam int unsigned ZSTR_IDX_W = $clog2(ZSTR_MAX_N);

  // Index of the first requester after ptr, searching ptr+1, ptr+2, ... mod n.
  // The loop runs downward so that the closest requester is written last.
  // When nothing requests, ptr is returned and the caller ignores it.
  function automatic int unsigned rr_next(input logic [ZSTR_MAX_N-1:0] req,
                                          input int unsigned ptr,
                                          input int unsigned n);
    int unsigned idx;
    logic [ZSTR_IDX_W-1:0] pos;
    idx = ptr;
    for (int unsigned k = ZSTR_MAX_N; k >= 1; k--) begin
      if (k <= n) begin
        pos = ZSTR_IDX_W'((ptr + k) % n);
        if (req[pos]) idx = 32'(pos);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/zstr_rr_pick.sv
// Combinational rotating find-first: picks the first set bit of req strictly
// after position ptr, wrapping modulo N. any flags that some bit is set.
module zstr_rr_pick
  import zstr_pkg::*;
#(
  parameter  int N  = 2,
  localparam int NW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [NW-1:0] ptr,
  output logic [NW-1:0] idx,
  output logic          any
);

  // Rotating search, then reduction for the "anyone asking" flag.
  always_comb begin
    idx = NW'(rr_next(ZSTR_MAX_N'(req), 32'(ptr), N));
    any = |req;
  end

endmodule

// File: rtl/zstr_arb.sv
// N-to-1 round-robin z-stream arbiter. A grant is held for a whole packet
// (closed by the lst beat); the winner then drops to lowest priority.
//
// Handshake: a beat moves on a rising edge where valid and ready are both
// high; valid never waits for ready, ready may depend combinationally on
// the sink's ready. In GRANT the granted source is wired straight through
// to the sink (s_rdy[g] = m_rdy), so both sides see the same transfer.
module zstr_arb
  import zstr_pkg::*;
#(
  parameter  int   N  = 2,
  parameter  int   BW = 1,
  parameter  logic XZ = 1'bx,
  localparam int   NW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    s_vld,
  input  logic [N*BW-1:0] s_bus,
  input  logic [N-1:0]    s_lst,
  output logic [N-1:0]    s_rdy,
  output logic            m_vld,
  output logic [BW-1:0]   m_bus,
  output logic            m_lst,
  input  logic            m_rdy,
  output logic [NW-1:0]   m_gnt,
  output logic            m_busy
);

  zstr_state_t   state_q;
  logic [NW-1:0] ptr_q;   // last winner; search starts just after it
  logic [NW-1:0] g_q;     // source holding the grant
  logic [NW-1:0] pick_idx;
  logic          pick_any;
  logic          trn;

  zstr_rr_pick #(.N(N)) u_pick (
    .req (s_vld),
    .ptr (ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign trn = m_vld & m_rdy;

  // Grant FSM: arbitrate in IDLE, hold until the granted packet's last beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= NW'(N - 1);
      g_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            g_q     <= pick_idx;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          // The forced return to IDLE gives the one-cycle bubble between packets.
          if (trn && s_lst[g_q]) begin
            ptr_q   <= g_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_busy = (state_q == GRANT);
  assign m_gnt  = g_q;

  // Pass-through mux from the granted source; everything parked while idle.
  always_comb begin
    s_rdy = '0;
    m_vld = 1'b0;
    m_lst = 1'b0;
    m_bus = {BW{XZ}};
    if (state_q == GRANT) begin
      m_vld      = s_vld[g_q];
      m_lst      = s_lst[g_q];
      m_bus      = s_bus[g_q*BW +: BW];
      s_rdy[g_q] = m_rdy;
    end
  end

endmodule

// File: tb/tb_zstr_arb.sv
// Self-checking bench for zstr_arb (N=4, BW=8): random traffic against a
// packet-level reference model plus directed grant-order checks.
module tb_zstr_arb;

  localparam int N  = 4;
  localparam int BW = 8;
  localparam int NW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    s_vld, s_lst, s_rdy;
  logic [N*BW-1:0] s_bus;
  logic            m_vld, m_lst, m_rdy, m_busy;
  logic [BW-1:0]   m_bus;
  logic [NW-1:0]   m_gnt;

  zstr_arb #(.N(N), .BW(BW)) dut (
    .clk    (clk),
    .rst    (rst),
    .s_vld  (s_vld),
    .s_bus  (s_bus),
    .s_lst  (s_lst),
    .s_rdy  (s_rdy),
    .m_vld  (m_vld),
    .m_bus  (m_bus),
    .m_lst  (m_lst),
    .m_rdy  (m_rdy),
    .m_gnt  (m_gnt),
    .m_busy (m_busy)
  );

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- sources and reference model ----------------
  // Beat format: {lst, src[1:0], seq[5:0]}.
  logic [8:0] dq [N][$];     // what each source still has to send
  logic [8:0] mq [N][$];     // model's copy of the same packets
  logic [8:0] exp_q [$];     // beats the sink should see, in order
  int         stall_left [N];
  int         stall_after [N];
  int         sent [N];
  int         stall_len;
  bit         rnd_rdy, rnd_stall;
  logic [N-1:0] hs;
  int         seq = 0;
  bit         mdl_busy;
  int         mdl_g, mdl_ptr;
  int         gnt_log [$];
  bit         prev_busy;

  task automatic add_pkt(input int src, input int len);
    logic [8:0] b;
    for (int k = 0; k < len; k++) begin
      b = {(k == len - 1) ? 1'b1 : 1'b0, 2'(src), 6'(seq)};
      seq++;
      dq[src].push_back(b);
      mq[src].push_back(b);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      dq[i].delete();
      mq[i].delete();
      stall_left[i] = 0;
    end
    exp_q.delete();
    hs        = '0;
    mdl_busy  = 1'b0;
    mdl_g     = 0;
    mdl_ptr   = N - 1;
    prev_busy = 1'b0;
  endtask

  // One clock: source bookkeeping, drive, check, advance the model.
  task automatic cycle();
    logic [N-1:0] er;
    logic [8:0]   b;
    bit           found;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        void'(dq[i].pop_front());
        sent[i]++;
        if (sent[i] == stall_after[i]) stall_left[i] = stall_len;
        else if (rnd_stall && $urandom_range(0, 7) == 0) stall_left[i] = $urandom_range(1, 3);
      end
    end
    for (int i = 0; i < N; i++) begin
      s_vld[i] = (dq[i].size() > 0) && (stall_left[i] == 0);
      if (dq[i].size() > 0) begin
        s_bus[i*BW +: BW] = dq[i][0][7:0];
        s_lst[i]          = dq[i][0][8];
      end else begin
        s_bus[i*BW +: BW] = 8'($urandom);
        s_lst[i]          = 1'($urandom_range(0, 1));
      end
      if (stall_left[i] > 0) stall_left[i]--;
    end
    m_rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    check("m_busy", 32'(m_busy), 32'(mdl_busy));
    check("m_gnt", 32'(m_gnt), 32'(mdl_g));
    er = '0;
    if (mdl_busy) begin
      er[mdl_g] = m_rdy;
      check("m_vld", 32'(m_vld), 32'(s_vld[mdl_g]));
      check("m_bus", 32'(m_bus), 32'(s_bus[mdl_g*BW +: BW]));
      check("m_lst", 32'(m_lst), 32'(s_lst[mdl_g]));
    end else begin
      check("m_vld_idle", 32'(m_vld), 32'd0);
    end
    check("s_rdy", 32'(s_rdy), 32'(er));
    if (m_busy && !prev_busy) gnt_log.push_back(int'(m_gnt));
    prev_busy = m_busy;
    hs = s_vld & s_rdy;
    // Model: a granted packet moves beat by beat; IDLE picks the next
    // requester after the previous winner, wrapping around.
    if (mdl_busy) begin
      if (s_vld[mdl_g] && m_rdy && mq[mdl_g].size() > 0) begin
        b = mq[mdl_g].pop_front();
        exp_q.push_back(b);
        if (b[8]) begin
          mdl_busy = 1'b0;
          mdl_ptr  = mdl_g;
        end
      end
    end else if (s_vld != '0) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        if (!found && s_vld[(mdl_ptr + k) % N]) begin
          mdl_g = (mdl_ptr + k) % N;
          found = 1'b1;
        end
      end
      mdl_busy = 1'b1;
    end
    if (m_vld && m_rdy) begin
      if (exp_q.size() == 0) check("sink_extra_beat", 32'd1, 32'd0);
      else begin
        b = exp_q.pop_front();
        check("sink_beat", 32'({m_lst, m_bus}), 32'(b));
      end
    end
  endtask

  task automatic run_drain(input int budget);
    int  n;
    bit  busy_any;
    n = 0;
    busy_any = 1'b1;
    while (busy_any && n < budget) begin
      cycle();
      n++;
      busy_any = mdl_busy || (exp_q.size() != 0);
      for (int i = 0; i < N; i++) if (dq[i].size() != 0) busy_any = 1'b1;
    end
    if (busy_any) check("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_gnts(input string tag, input int exp_list [$]);
    check({tag, "_count"}, 32'(gnt_log.size()), 32'(exp_list.size()));
    for (int k = 0; k < exp_list.size() && k < gnt_log.size(); k++)
      check(tag, 32'(gnt_log[k]), 32'(exp_list[k]));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int exp_list [$];
    s_vld = '0; s_bus = '0; s_lst = '0; m_rdy = 1'b0;
    rnd_rdy = 1'b0; rnd_stall = 1'b0; stall_len = 0;
    for (int i = 0; i < N; i++) begin
      stall_after[i] = -1;
      sent[i] = 0;
    end
    model_reset();

    repeat (3) @(negedge clk);
    #1;
    check("rst_m_busy", 32'(m_busy), 32'd0);
    check("rst_m_gnt", 32'(m_gnt), 32'd0);
    check("rst_m_vld", 32'(m_vld), 32'd0);
    check("rst_m_lst", 32'(m_lst), 32'd0);
    check("rst_s_rdy", 32'(s_rdy), 32'd0);
    rst = 1'b0;

    // Fairness: every source streams single-beat packets.
    gnt_log.delete();
    for (int r = 0; r < 3; r++) for (int i = 0; i < N; i++) add_pkt(i, 1);
    run_drain(200);
    exp_list.delete();
    for (int k = 0; k < 12; k++) exp_list.push_back(k % N);
    check_gnts("fair_order", exp_list);

    // Packet lock: src1 three beats, src2 waits behind it.
    gnt_log.delete();
    add_pkt(1, 3);
    add_pkt(2, 1);
    run_drain(100);
    exp_list = '{1, 2};
    check_gnts("lock_order", exp_list);

    // Backpressure on a 5-beat packet.
    rnd_rdy = 1'b1;
    add_pkt(0, 5);
    run_drain(300);
    rnd_rdy = 1'b0;

    // Sole requester at the top index keeps winning.
    gnt_log.delete();
    for (int k = 0; k < 4; k++) add_pkt(3, 1);
    run_drain(100);
    exp_list = '{3, 3, 3, 3};
    check_gnts("sole_order", exp_list);

    // Stall: src0 drops valid for 10 cycles after beat 2, src1 waiting.
    gnt_log.delete();
    for (int i = 0; i < N; i++) sent[i] = 0;
    stall_after[0] = 2;
    stall_len = 10;
    add_pkt(0, 5);
    add_pkt(1, 2);
    run_drain(200);
    stall_after[0] = -1;
    exp_list = '{0, 1};
    check_gnts("stall_order", exp_list);

    // Random mixed traffic.
    rnd_rdy = 1'b1;
    rnd_stall = 1'b1;
    for (int k = 0; k < 40; k++) add_pkt($urandom_range(0, N - 1), $urandom_range(1, 4));
    run_drain(3000);
    rnd_rdy = 1'b0;
    rnd_stall = 1'b0;

    // Reset in the middle of a packet with the sink ready.
    add_pkt(1, 4);
    repeat (3) cycle();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_m_vld", 32'(m_vld), 32'd0);
    check("midrst_s_rdy", 32'(s_rdy), 32'd0);
    check("midrst_m_busy", 32'(m_busy), 32'd0);
    check("midrst_m_gnt", 32'(m_gnt), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    s_vld = '0;
    gnt_log.delete();
    for (int i = 0; i < N; i++) add_pkt(i, 1);
    run_drain(100);
    exp_list = '{0, 1, 2, 3};
    check_gnts("post_rst_order", exp_list);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
